// File: rtl/tqvp_htfab_color_vga.sv
// tqvp_htfab_color_vga
//   Colour VGA peripheral for the TinyQV bus. Holds a BPP-bit-per-pixel
//   framebuffer reached through an auto-incrementing indirect port, a 4-entry
//   palette, a sync generator, a double-buffered line buffer and a vblank
//   interrupt with explicit clear.
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   address         register byte address (0x00 CTRL, 0x04 STATUS, 0x08 PALETTE,
//                   0x0C FB_ADDR, 0x10 FB_DATA)
//   data_in         write data
//   data_write_n    11 none, 00 8b, 01 16b, 10 32b
//   data_read_n     11 none, otherwise read request
//   data_out        read data, valid while data_ready, else 0
//   data_ready      one-cycle read completion strobe
//   uo_out          {hsync, B0, G0, R0, vsync, B1, G1, R1}, registered
//   user_interrupt  vblank flag gated by CTRL[1]
module tqvp_htfab_color_vga #(
    parameter int COLS        = 32,
    parameter int ROWS        = 16,
    parameter int BPP         = 2,
    parameter int CLK_PER_PIX = 48,
    parameter int LINE_REP    = 30,
    parameter int H_ACTIVE    = 1536,
    parameter int H_FP        = 64,
    parameter int H_SYNC      = 240,
    parameter int H_BP        = 192,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic [7:0]  uo_out,
    output logic        user_interrupt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int RW      = COLS * BPP / 32;
    localparam int WORDS   = RW * ROWS;
    localparam int LB_W    = RW * 32;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW      = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    localparam int LW      = (LINE_REP > 1) ? $clog2(LINE_REP) : 1;
    localparam int RWW     = $clog2(ROWS + 1);

    logic [HW-1:0]   r_hcount;
    logic [VW-1:0]   r_vcount;
    logic [PW-1:0]   r_psub;
    logic [CW-1:0]   r_pcol;
    logic [LW-1:0]   r_vsub;
    logic [RWW-1:0]  r_vrow;
    logic [1:0]      r_ctrl;
    logic [31:0]     r_palette;
    logic [AW-1:0]   r_fb_addr;
    logic            r_flag;
    logic            r_rd_d;
    logic            r_ready;
    logic [31:0]     r_data_out;
    logic [7:0]      r_uo;
    logic [LB_W-1:0] r_shadow;
    logic [LB_W-1:0] r_disp;
    logic [31:0]     r_fb [WORDS];

    logic            w_wr, w_rd, w_rd_go, w_fb_wr, w_fb_rd;
    logic            w_line_end, w_active, w_in_vblank, w_hsync, w_vsync;
    logic            w_fetch_en, w_flag_set;
    logic [HW-1:0]   w_fetch_k;
    logic [RWW-1:0]  w_next_row;
    logic [AW-1:0]   w_fetch_addr, w_addr_inc;
    logic [31:0]     w_fetch_word, w_cpu_word, w_rdata;
    logic [BPP-1:0]  w_index;
    logic [5:0]      w_colour;

    assign w_wr        = data_write_n != 2'b11;
    assign w_rd        = data_read_n != 2'b11;
    // A held request is accepted only on its first cycle.
    assign w_rd_go     = w_rd && !r_rd_d;
    assign w_fb_wr     = data_write_n == 2'b10 && address == 6'h10;
    assign w_fb_rd     = w_rd_go && address == 6'h10;
    assign w_addr_inc  = (r_fb_addr == AW'(WORDS - 1)) ? '0 : r_fb_addr + 1'b1;

    assign w_line_end  = r_hcount == HW'(H_TOTAL - 1);
    assign w_active    = r_hcount < HW'(H_ACTIVE) && r_vcount < VW'(V_ACTIVE);
    assign w_in_vblank = r_vcount >= VW'(V_ACTIVE);
    assign w_hsync     = !(r_hcount >= HW'(H_ACTIVE + H_FP) && r_hcount < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vsync     = !(r_vcount >= VW'(V_ACTIVE + V_FP) && r_vcount < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign w_flag_set  = r_hcount == '0 && r_vcount == VW'(V_ACTIVE);

    // Row shown on the next scanline; past the last row (blanking) fetch row 0.
    always_comb begin
        if (r_vcount == VW'(V_TOTAL - 1))
            w_next_row = '0;
        else if (r_vsub == LW'(LINE_REP - 1))
            w_next_row = r_vrow + 1'b1;
        else
            w_next_row = r_vrow;
        if (w_next_row >= RWW'(ROWS))
            w_next_row = '0;
    end

    assign w_fetch_en   = r_hcount >= HW'(H_ACTIVE) && r_hcount < HW'(H_ACTIVE + RW);
    assign w_fetch_k    = r_hcount - HW'(H_ACTIVE);
    assign w_fetch_addr = AW'(32'(w_next_row) * RW + 32'(w_fetch_k));
    assign w_fetch_word = r_fb[w_fetch_addr];
    assign w_cpu_word   = r_fb[r_fb_addr];

    assign w_index  = r_disp[32'(r_pcol) * BPP +: BPP];
    assign w_colour = (w_active && r_ctrl[0]) ? r_palette[32'(w_index) * 8 +: 6] : '0;

    always_comb begin
        w_rdata = '0;
        case (address)
            6'h00: w_rdata = {30'b0, r_ctrl};
            6'h04: w_rdata = {6'b0, 10'(r_vcount), 14'b0, w_in_vblank, r_flag};
            6'h08: w_rdata = r_palette;
            6'h0C: w_rdata = 32'(r_fb_addr);
            6'h10: w_rdata = w_cpu_word;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount   <= '0;
            r_vcount   <= '0;
            r_psub     <= '0;
            r_pcol     <= '0;
            r_vsub     <= '0;
            r_vrow     <= '0;
            r_ctrl     <= 2'b01;
            r_palette  <= 32'h0C30_3F00;
            r_fb_addr  <= '0;
            r_flag     <= 1'b0;
            r_rd_d     <= 1'b0;
            r_ready    <= 1'b0;
            r_data_out <= '0;
            r_uo       <= 8'h88;
            r_shadow   <= '0;
            r_disp     <= '0;
        end else begin
            if (w_line_end) begin
                r_hcount <= '0;
                r_psub   <= '0;
                r_pcol   <= '0;
                r_disp   <= r_shadow;
                if (r_vcount == VW'(V_TOTAL - 1)) begin
                    r_vcount <= '0;
                    r_vsub   <= '0;
                    r_vrow   <= '0;
                end else begin
                    r_vcount <= r_vcount + 1'b1;
                    if (r_vsub == LW'(LINE_REP - 1)) begin
                        r_vsub <= '0;
                        if (r_vrow != RWW'(ROWS - 1))
                            r_vrow <= r_vrow + 1'b1;
                    end else begin
                        r_vsub <= r_vsub + 1'b1;
                    end
                end
            end else begin
                r_hcount <= r_hcount + 1'b1;
                // Column advances every CLK_PER_PIX cycles, holding at the last column.
                if (r_psub == PW'(CLK_PER_PIX - 1)) begin
                    r_psub <= '0;
                    if (r_pcol != CW'(COLS - 1))
                        r_pcol <= r_pcol + 1'b1;
                end else begin
                    r_psub <= r_psub + 1'b1;
                end
            end

            for (int unsigned k = 0; k < RW; k++)
                if (w_fetch_en && w_fetch_k == HW'(k))
                    r_shadow[k*32 +: 32] <= w_fetch_word;

            r_uo <= {w_hsync, w_colour[0], w_colour[2], w_colour[4],
                     w_vsync, w_colour[1], w_colour[3], w_colour[5]};

            if (w_wr && address == 6'h00) r_ctrl <= data_in[1:0];
            if (w_wr && address == 6'h08) r_palette <= data_in;
            if (w_wr && address == 6'h0C)
                r_fb_addr <= AW'(data_in % 32'(WORDS));
            else if (w_fb_wr || w_fb_rd)
                r_fb_addr <= w_addr_inc;

            // Set has priority over a simultaneous clear.
            if (w_flag_set)
                r_flag <= 1'b1;
            else if (w_wr && address == 6'h04 && data_in[0])
                r_flag <= 1'b0;

            r_rd_d     <= w_rd;
            r_ready    <= w_rd_go;
            r_data_out <= w_rd_go ? w_rdata : '0;
        end
    end

    // Framebuffer contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_fb_wr)
            r_fb[r_fb_addr] <= data_in;
    end

    assign data_out       = r_data_out;
    assign data_ready     = r_ready;
    assign uo_out         = r_uo;
    assign user_interrupt = r_flag & r_ctrl[1];
endmodule

// File: tb/tb_tqvp_htfab_color_vga.sv
module tb_tqvp_htfab_color_vga;
    localparam int COLS = 32, ROWS = 4, BPP = 2, CPP = 2, LR = 2;
    localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 8, VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int RW = COLS * BPP / 32;
    localparam int WORDS = RW * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic [7:0]  uo_out;
    logic        user_interrupt;

    always #5 clk = ~clk;

    tqvp_htfab_color_vga #(
        .COLS(COLS), .ROWS(ROWS), .BPP(BPP), .CLK_PER_PIX(CPP), .LINE_REP(LR),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .uo_out(uo_out), .user_interrupt(user_interrupt)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: screen position, registers, framebuffer, line buffers.
    int          mh, mv, m_addr;
    logic [1:0]  m_ctrl;
    logic [31:0] m_pal;
    bit          m_flag, m_prev_rd, m_started;
    logic [31:0] m_fb [WORDS];
    bit          m_fb_ok [WORDS];
    logic [31:0] m_shadow [RW];
    logic [31:0] m_disp [RW];
    bit          m_sh_ok [RW];
    bit          m_disp_ok [RW];
    logic [7:0]  exp_uo, exp_mask;
    logic        exp_irq;
    logic [31:0] rd_q [$];

    initial begin
        logic hs, vs, cok, rd;
        logic [5:0] c;
        logic [31:0] v32;
        int x, w, idx, nl, row, k;
        m_started = 0;
        forever begin
            @(posedge clk);
            m_started = 1;
            if (rst) begin
                mh = 0; mv = 0; m_addr = 0; m_ctrl = 2'b01; m_pal = 32'h0C303F00;
                m_flag = 0; m_prev_rd = 0;
                for (int i = 0; i < RW; i++) begin m_sh_ok[i] = 0; m_disp_ok[i] = 0; end
                exp_uo = 8'h88; exp_mask = 8'hFF; exp_irq = 0;
            end else begin
                hs = !(mh >= HA + HFP && mh < HA + HFP + HSY);
                vs = !(mv >= VA + VFP && mv < VA + VFP + VSY);
                c = '0; cok = 1;
                if (mh < HA && mv < VA && m_ctrl[0]) begin
                    x = mh / CPP;
                    w = x * BPP / 32;
                    idx = int'((m_disp[w] >> ((x * BPP) % 32)) & ((32'd1 << BPP) - 1));
                    c = 6'((m_pal >> (8 * idx)) & 32'h3F);
                    cok = m_disp_ok[w];
                end
                exp_uo = {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
                exp_mask = cok ? 8'hFF : 8'h88;
                if (mh >= HA && mh < HA + RW) begin
                    k = mh - HA;
                    nl = (mv + 1) % VT;
                    row = nl / LR;
                    if (row >= ROWS) row = 0;
                    m_shadow[k] = m_fb[row * RW + k];
                    m_sh_ok[k] = m_fb_ok[row * RW + k];
                end
                if (mh == HT - 1)
                    for (int i = 0; i < RW; i++) begin m_disp[i] = m_shadow[i]; m_disp_ok[i] = m_sh_ok[i]; end
                rd = data_read_n != 2'b11;
                if (rd && !m_prev_rd) begin
                    case (address)
                        6'h00: v32 = {30'b0, m_ctrl};
                        6'h04: v32 = {6'b0, 10'(mv), 14'b0, mv >= VA, m_flag};
                        6'h08: v32 = m_pal;
                        6'h0C: v32 = 32'(m_addr);
                        6'h10: begin v32 = m_fb[m_addr]; m_addr = (m_addr + 1) % WORDS; end
                        default: v32 = '0;
                    endcase
                    rd_q.push_back(v32);
                end
                m_prev_rd = rd;
                if (data_write_n != 2'b11) begin
                    case (address)
                        6'h00: m_ctrl = data_in[1:0];
                        6'h08: m_pal = data_in;
                        6'h0C: m_addr = int'(data_in % WORDS);
                        6'h10: if (data_write_n == 2'b10) begin
                            m_fb[m_addr] = data_in; m_fb_ok[m_addr] = 1;
                            m_addr = (m_addr + 1) % WORDS;
                        end
                        default: ;
                    endcase
                end
                if (mh == 0 && mv == VA) m_flag = 1;
                else if (data_write_n != 2'b11 && address == 6'h04 && data_in[0]) m_flag = 0;
                exp_irq = m_flag & m_ctrl[1];
                mh++;
                if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
            end
        end
    end

    // Monitor: streams video/irq checks and pops read expectations on each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("uo_out", 32'(uo_out & exp_mask), 32'(exp_uo & exp_mask));
                check("user_interrupt", 32'(user_interrupt), 32'(exp_irq));
                check("data_ready", 32'(data_ready), 32'(rd_q.size() > 0));
                if (data_ready && rd_q.size() > 0) check("data_out", data_out, rd_q.pop_front());
                else if (!data_ready) check("data_out_idle", data_out, 32'h0);
            end
        end
    end

    // Bus ops drive at the current negedge and hold for exactly one clock edge.
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        address = a; data_in = d; data_write_n = wn;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a);
        logic [1:0] rn;
        rn = 2'($urandom_range(0, 2));
        address = a; data_read_n = rn;
        @(negedge clk);
        data_read_n = 2'b11;
        @(negedge clk);
    endtask

    task automatic wait_pos(input int v, input int h, input string name);
        int n;
        n = 0;
        while (!(mv == v && mh == h)) begin
            @(negedge clk);
            n++;
            if (n > 2 * HT * VT) begin
                n_checks++; n_fail++;
                $display("FAIL timeout %s: position (%0d,%0d) not reached", name, v, h);
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] addrs [7];
        logic [5:0] a;
        logic [1:0] wn;
        addrs[0] = 6'h00; addrs[1] = 6'h04; addrs[2] = 6'h08; addrs[3] = 6'h0C;
        addrs[4] = 6'h10; addrs[5] = 6'h14; addrs[6] = 6'h3C;

        repeat (3) @(negedge clk);
        check("reset_uo", 32'(uo_out), 32'h88);
        check("reset_ready", 32'(data_ready), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        bus_write(6'h0C, 32'h0, 2'b10);
        for (int i = 0; i < WORDS; i++) bus_write(6'h10, $urandom, 2'b10);

        bus_write(6'h0C, 32'd5, 2'b10);
        bus_write(6'h10, 32'hA5A5A5A5, 2'b10);
        bus_write(6'h10, 32'h12345678, 2'b10);
        bus_write(6'h0C, 32'd5, 2'b10);
        bus_read(6'h10);
        bus_read(6'h10);
        bus_read(6'h0C);
        bus_write(6'h0C, WORDS - 1, 2'b10);
        bus_write(6'h10, 32'hDEADBEEF, 2'b10);
        bus_write(6'h10, 32'hCAFEF00D, 2'b10);
        bus_write(6'h0C, WORDS + WORDS - 1, 2'b10);
        bus_read(6'h10);
        bus_read(6'h10);
        bus_read(6'h0C);
        bus_write(6'h10, 32'h11111111, 2'b00);
        bus_read(6'h0C);
        address = 6'h10; data_read_n = 2'b00;
        repeat (3) @(negedge clk);
        data_read_n = 2'b11;
        @(negedge clk);
        bus_read(6'h0C);

        bus_write(6'h0C, 32'h0, 2'b10);
        bus_write(6'h10, 32'h00000002, 2'b10);
        bus_write(6'h10, 32'h00000000, 2'b10);
        wait_pos(1, 0, "line1");
        wait_pos(0, 1, "pix0");
        check("pixel0_red", 32'(uo_out), 32'h99);
        wait_pos(0, CPP + 1, "pix1");
        check("pixel1_black", 32'(uo_out), 32'h88);

        wait_pos(2, HA + HFP, "hs_pre");
        check("hsync_pre", 32'(uo_out[7]), 32'h1);
        @(negedge clk);
        check("hsync_first_low", 32'(uo_out[7]), 32'h0);
        wait_pos(2, HA + HFP + HSY, "hs_last");
        check("hsync_last_low", 32'(uo_out[7]), 32'h0);
        @(negedge clk);
        check("hsync_release", 32'(uo_out[7]), 32'h1);
        wait_pos(VA + VFP, 0, "vs_pre");
        check("vsync_pre", 32'(uo_out[3]), 32'h1);
        @(negedge clk);
        check("vsync_first_low", 32'(uo_out[3]), 32'h0);
        wait_pos(VA + VFP + VSY, 0, "vs_last");
        check("vsync_last_low", 32'(uo_out[3]), 32'h0);
        @(negedge clk);
        check("vsync_release", 32'(uo_out[3]), 32'h1);

        bus_write(6'h00, 32'h3, 2'b10);
        bus_write(6'h04, 32'h1, 2'b10);
        wait_pos(VA, 0, "irq_pre");
        check("irq_before_set", 32'(user_interrupt), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(user_interrupt), 32'h1);
        bus_read(6'h04);
        bus_write(6'h04, 32'h1, 2'b01);
        check("irq_cleared", 32'(user_interrupt), 32'h0);
        wait_pos(VA, 0, "irq_race");
        bus_write(6'h04, 32'h1, 2'b10);
        check("irq_set_beats_clear", 32'(user_interrupt), 32'h1);
        bus_write(6'h04, 32'h1, 2'b10);

        wait_pos(1, 0, "ctrl_off_pre");
        bus_write(6'h00, 32'h0, 2'b10);
        wait_pos(2, 5, "ctrl_off");
        check("ctrl_off_colour", 32'(uo_out), 32'h88);
        bus_write(6'h00, 32'h1, 2'b10);

        for (int i = 0; i < 400; i++) begin
            a = addrs[$urandom_range(0, 6)];
            if ($urandom_range(0, 1) == 0) begin
                wn = 2'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 0) wn = 2'b10;
                bus_write(a, (a == 6'h0C) ? $urandom_range(0, 3 * WORDS) : $urandom, wn);
            end else begin
                bus_read(a);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_pos(3, 20, "reset_mid");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_uo", 32'(uo_out), 32'h88);
        check("rst_irq", 32'(user_interrupt), 32'h0);
        @(negedge clk);
        bus_read(6'h00);
        bus_read(6'h04);
        bus_read(6'h08);
        bus_read(6'h0C);
        repeat (2 * HT) @(negedge clk);
        check("read_queue_drained", 32'(rd_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
